pindex_readout_ctrl: RTL

- Sequences the post-processing readout of pooling indices from the encoder's pooling-index store.
- Issues `pindex_rd` / `pindex_rd_addr` read requests in address order and captures the returned `pindex_in` after a fixed memory latency.
- Streams the captured values out on a valid/ready interface with full backpressure support.
- Sits between the encoder (driving its `pindex_rd`, `pindex_rd_addr` and taking its `pindex_out`) and the downstream decoder/unpool logic or the bench dump.

---
 rtl/pindex_readout_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pindex_readout_ctrl.sv
// Pooling-index readout sequencer: issues ordered reads to the index store, captures the
// returned data after a fixed latency and streams it out through a small credit-guarded skid FIFO.
module pindex_readout_ctrl #(
  parameter int unsigned INDEX_ADDR_WIDTH = 10,
  parameter int unsigned PINDEX_WIDTH     = 2,
  parameter int unsigned N_ENTRIES        = 1024,
  parameter int unsigned RD_LATENCY       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        pindex_rd,
  output logic [INDEX_ADDR_WIDTH-1:0] pindex_rd_addr,
  input  logic [PINDEX_WIDTH-1:0]     pindex_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [PINDEX_WIDTH-1:0]     m_data,
  output logic [INDEX_ADDR_WIDTH-1:0] m_addr,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned AW         = INDEX_ADDR_WIDTH;
  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int unsigned IW         = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic                    rd_d, done_d;
  logic [AW-1:0]           rd_addr_d;

  logic [RD_LATENCY-1:0]   pipe_vld;
  logic [AW-1:0]           pipe_addr [RD_LATENCY];

  logic [PINDEX_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0]           fifo_addr [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [CW-1:0]           fifo_cnt, fifo_cnt_d;
  logic [CW-1:0]           inflight_d;
  logic [IW-1:0]           wr_idx;
  logic                    push, pop, can_issue;

  assign push       = pipe_vld[RD_LATENCY-1];
  assign pop        = m_valid && m_ready;
  assign fifo_cnt_d = fifo_cnt - CW'(pop) + CW'(push);
  assign wr_idx     = IW'(fifo_cnt - CW'(pop));

  assign m_data = fifo_data[0];
  assign m_addr = fifo_addr[0];
  assign m_last = fifo_last[0];

  // Credit for the next cycle's strobe: FIFO occupancy and in-flight reads as they will be after this edge.
  always_comb begin
    inflight_d = CW'(pindex_rd);
    for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
      inflight_d = inflight_d + CW'(pipe_vld[i]);
    end
    can_issue = (CW'(fifo_cnt_d + inflight_d) < CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = 1'b0;
    rd_addr_d = pindex_rd_addr;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = (LAST_ADDR == '0) ? DRAIN : READ;
          rd_d      = 1'b1;
          rd_addr_d = '0;
          cnt_d     = AW'(1);
        end
      end
      READ: begin
        if (can_issue) begin
          rd_d      = 1'b1;
          rd_addr_d = cnt_q;
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pindex_rd && (pipe_vld == '0) && (fifo_cnt == '0)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pindex_rd      <= 1'b0;
      pindex_rd_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pindex_rd      <= rd_d;
      pindex_rd_addr <= rd_addr_d;
      busy           <= (state_d == READ) || (state_d == DRAIN);
      done           <= done_d;
    end
  end

  // Strobe-flag pipeline and shift-on-pop FIFO; the head always sits in slot 0.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      pipe_vld <= '0;
      fifo_cnt <= '0;
      m_valid  <= 1'b0;
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe_addr[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0]  <= pindex_rd;
      pipe_addr[0] <= pindex_rd_addr;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
      if (pop) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
          fifo_data[i] <= fifo_data[i+1];
          fifo_addr[i] <= fifo_addr[i+1];
          fifo_last[i] <= fifo_last[i+1];
        end
      end
      if (push) begin
        fifo_data[wr_idx] <= pindex_in;
        fifo_addr[wr_idx] <= pipe_addr[RD_LATENCY-1];
        fifo_last[wr_idx] <= (pipe_addr[RD_LATENCY-1] == LAST_ADDR);
      end
      fifo_cnt <= fifo_cnt_d;
      m_valid  <= (fifo_cnt_d != '0);
    end
  end

endmodule
